sync_fifo_rv_drain: RTL and testbench

//  Downstream drain stage for sync_fifo. It converts the FIFO's raw
//  rd_en / empty / registered-dout interface into a valid/ready stream

---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/rv_skid_buf.sv | 58 +++++
 rtl/sync_fifo_rv_drain.sv | 49 ++++
 tb/tb_sync_fifo_rv_drain.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for sync_fifo and its downstream drain stage.
package sync_fifo_pkg;
  localparam int DATA_WIDTH = 64;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Index width for a circular buffer of 'depth' entries (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rv_skid_buf.sv
// Circular skid buffer presenting its head as a valid/ready stream.
// Push is a captured FIFO word; pop is the stream handshake.
module rv_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             m_ready,
  output logic                             m_valid,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
);
  localparam int PW = ptr_w(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PW-1:0] wr_idx, rd_idx;
  logic [CW-1:0] count;
  logic          pop;

  // Wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (i == LAST) ? '0 : i + PW'(1);
  endfunction

  assign m_valid   = (count != '0);
  assign m_data    = mem[rd_idx];
  assign occupancy = count;
  assign pop       = m_valid & m_ready;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= nxt(wr_idx);
      end
      if (pop) rd_idx <= nxt(rd_idx);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!rst)
    count <= CW'(BUF_DEPTH));
  a_hold_stable: assert property (@(posedge clock) disable iff (!rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
endmodule

// File: rtl/sync_fifo_rv_drain.sv
// Drains sync_fifo into a valid/ready stream. Reads are issued only against
// free buffer credit, so fifo_rd_en never depends on m_ready.
module sync_fifo_rv_drain
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic          inflight;
  logic [CW:0]   used;

  // Held words plus the word already on its way must leave room for one more.
  assign used       = {1'b0, occupancy} + (CW+1)'(inflight);
  assign fifo_rd_en = rst & !fifo_empty & (used < (CW+1)'(BUF_DEPTH));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_rd_en;
  end

  rv_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  a_rd_not_empty: assert property (@(posedge clock) disable iff (!rst)
    fifo_rd_en |-> !fifo_empty);
endmodule

// File: tb/tb_sync_fifo_rv_drain.sv
// Bench for sync_fifo_rv_drain: queue-based FIFO models feed a depth-3 and a
// depth-2 instance; delivered words are compared to the pushed order.
module tb_sync_fifo_rv_drain;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // depth-3 instance and its FIFO model
  logic [DW-1:0] dout3 = '0, m_data3;
  logic empty3, rd_en3, m_valid3, m_ready3 = 1'b0;
  logic [1:0] occ3;
  logic [DW-1:0] mem3 [1024];
  int wr3 = 0, rd3 = 0;
  logic [DW-1:0] exp3[$];
  assign empty3 = (wr3 == rd3);

  // depth-2 instance and its FIFO model
  logic [DW-1:0] dout2 = '0, m_data2;
  logic empty2, rd_en2, m_valid2, m_ready2 = 1'b0;
  logic [1:0] occ2;
  logic [DW-1:0] mem2 [1024];
  int wr2 = 0, rd2 = 0;
  logic [DW-1:0] exp2[$];
  assign empty2 = (wr2 == rd2);

  sync_fifo_rv_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(3)) dut3 (
    .clock(clock), .rst(rst), .fifo_dout(dout3), .fifo_empty(empty3),
    .fifo_rd_en(rd_en3), .m_data(m_data3), .m_valid(m_valid3),
    .m_ready(m_ready3), .occupancy(occ3));

  sync_fifo_rv_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut2 (
    .clock(clock), .rst(rst), .fifo_dout(dout2), .fifo_empty(empty2),
    .fifo_rd_en(rd_en2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(m_ready2), .occupancy(occ2));

  // registered-dout FIFO: read accepted at an edge shows data after that edge
  always @(posedge clock or negedge rst) begin
    if (!rst) begin rd3 <= wr3; dout3 <= '0; end
    else if (rd_en3) begin dout3 <= mem3[rd3 % 1024]; rd3 <= rd3 + 1; end
  end
  always @(posedge clock or negedge rst) begin
    if (!rst) begin rd2 <= wr2; dout2 <= '0; end
    else if (rd_en2) begin dout2 <= mem2[rd2 % 1024]; rd2 <= rd2 + 1; end
  end

  // monitors: sampled mid-cycle, a handshake seen here pops at the next edge
  logic [DW-1:0] rx3_data[$], rx2_data[$];
  int rx3_cyc[$], rd3_cyc[$], rx2_cyc[$], rd2_cyc[$];
  int occ3_max = 0, stab3_err = 0;
  logic hold3 = 1'b0;
  logic [DW-1:0] hold3_data = '0;

  always @(negedge clock) begin
    if (!rst) hold3 = 1'b0;
    else begin
      if (hold3 && (!m_valid3 || m_data3 !== hold3_data)) stab3_err++;
      hold3 = m_valid3 && !m_ready3;
      hold3_data = m_data3;
      if (m_valid3 && m_ready3) begin rx3_data.push_back(m_data3); rx3_cyc.push_back(cyc); end
      if (rd_en3) rd3_cyc.push_back(cyc);
      if (int'(occ3) > occ3_max) occ3_max = int'(occ3);
    end
  end
  always @(negedge clock) begin
    if (rst) begin
      if (m_valid2 && m_ready2) begin rx2_data.push_back(m_data2); rx2_cyc.push_back(cyc); end
      if (rd_en2) rd2_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push3(input logic [DW-1:0] d);
    mem3[wr3 % 1024] = d; wr3++; exp3.push_back(d);
  endtask

  task automatic push2(input logic [DW-1:0] d);
    mem2[wr2 % 1024] = d; wr2++; exp2.push_back(d);
  endtask

  task automatic clear_logs3();
    rx3_data.delete(); rx3_cyc.delete(); rd3_cyc.delete();
    occ3_max = 0; stab3_err = 0;
  endtask

  task automatic test_reset();
    m_ready3 = 1'b1; m_ready2 = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rd_en3, m_valid3, occ3} !== 4'b0 || m_data3 !== '0) begin
      errors++;
      $display("FAIL reset_state got rd_en=%b valid=%b occ=%0d data=%h, want all 0", rd_en3, m_valid3, occ3, m_data3);
    end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({rd_en3, m_valid3, occ3} !== 4'b0 || m_data3 !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got rd_en=%b valid=%b occ=%0d data=%h, want all 0", i, rd_en3, m_valid3, occ3, m_data3);
      end
    end
    tick();
  endtask

  task automatic test_stream();
    clear_logs3();
    for (int i = 1; i <= 8; i++) push3(DW'(i));
    for (int k = 0; k < 40 && rx3_data.size() < 8; k++) tick();
    checks++;
    if (rx3_data.size() != 8) begin
      errors++; $display("FAIL stream_count got %0d want 8", rx3_data.size());
    end
    for (int i = 0; i < rx3_data.size() && i < 8; i++) begin
      checks++;
      if (rx3_data[i] !== exp3[i] || rx3_cyc[i] != rx3_cyc[0] + i) begin
        errors++;
        $display("FAIL stream_word %0d got %h at +%0d want %h at +%0d", i, rx3_data[i], rx3_cyc[i] - rx3_cyc[0], exp3[i], i);
      end
    end
    if (rx3_data.size() > 0 && rd3_cyc.size() > 0) begin
      checks++;
      if (rx3_cyc[0] != rd3_cyc[0] + 2) begin
        errors++; $display("FAIL stream_latency got %0d want 2", rx3_cyc[0] - rd3_cyc[0]);
      end
    end
    exp3.delete();
  endtask

  task automatic test_backpressure();
    m_ready3 = 1'b0;
    clear_logs3();
    for (int i = 'h10; i <= 'h17; i++) push3(DW'(i));
    repeat (10) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (rd_en3 !== 1'b0 || m_valid3 !== 1'b1 || occ3 !== 2'd3 || m_data3 !== DW'('h10)) begin
        errors++;
        $display("FAIL stall_hold got rd_en=%b valid=%b occ=%0d data=%h want 0,1,3,10", rd_en3, m_valid3, occ3, m_data3);
      end
    end
    checks++;
    if (rd3_cyc.size() != 3) begin
      errors++; $display("FAIL stall_reads got %0d want 3", rd3_cyc.size());
    end
    tick();
  endtask

  task automatic test_toggle();
    m_ready3 = 1'b0;
    for (int k = 0; k < 80 && rx3_data.size() < 8; k++) begin
      m_ready3 = ~m_ready3;
      tick();
    end
    m_ready3 = 1'b1;
    checks++;
    if (rx3_data.size() != 8) begin
      errors++; $display("FAIL toggle_count got %0d want 8", rx3_data.size());
    end
    for (int i = 0; i < rx3_data.size() && i < 8; i++) begin
      checks++;
      if (rx3_data[i] !== exp3[i]) begin
        errors++; $display("FAIL toggle_word %0d got %h want %h", i, rx3_data[i], exp3[i]);
      end
    end
    checks++;
    if (occ3_max > 3 || stab3_err != 0) begin
      errors++; $display("FAIL toggle_hold got occ_max=%0d stab_err=%0d want <=3,0", occ3_max, stab3_err);
    end
    exp3.delete();
  endtask

  task automatic test_reset_midstream();
    logic seen;
    m_ready3 = 1'b1;
    clear_logs3();
    for (int i = 'h20; i <= 'h27; i++) push3(DW'(i));
    tick(); tick();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      seen = rd_en3;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_read got no read want a read"); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid3 !== 1'b0 || occ3 !== 2'd0 || m_data3 !== '0 || rd_en3 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got valid=%b occ=%0d data=%h rd_en=%b want 0", m_valid3, occ3, m_data3, rd_en3);
    end
    exp3.delete();
    tick();
    rst = 1'b1;
    clear_logs3();
    repeat (10) tick();
    checks++;
    if (rx3_data.size() != 0 || m_valid3 !== 1'b0) begin
      errors++; $display("FAIL midrst_stale got %0d words valid=%b want 0", rx3_data.size(), m_valid3);
    end
    for (int i = 'h30; i <= 'h33; i++) push3(DW'(i));
    for (int k = 0; k < 30 && rx3_data.size() < 4; k++) tick();
    checks++;
    if (rx3_data.size() != 4) begin
      errors++; $display("FAIL midrst_count got %0d want 4", rx3_data.size());
    end
    for (int i = 0; i < rx3_data.size() && i < 4; i++) begin
      checks++;
      if (rx3_data[i] !== exp3[i]) begin
        errors++; $display("FAIL midrst_word %0d got %h want %h", i, rx3_data[i], exp3[i]);
      end
    end
    exp3.delete();
  endtask

  task automatic test_depth2();
    // credit rule with two entries: deliveries at +0,+1,+3,+4 from the first
    int offs [4] = '{0, 1, 3, 4};
    m_ready2 = 1'b1;
    rx2_data.delete(); rx2_cyc.delete(); rd2_cyc.delete();
    for (int i = 'hA; i <= 'hD; i++) push2(DW'(i));
    for (int k = 0; k < 40 && rx2_data.size() < 4; k++) tick();
    checks++;
    if (rx2_data.size() != 4) begin
      errors++; $display("FAIL d2_count got %0d want 4", rx2_data.size());
    end
    for (int i = 0; i < rx2_data.size() && i < 4; i++) begin
      checks++;
      if (rx2_data[i] !== exp2[i] || rx2_cyc[i] - rx2_cyc[0] != offs[i]) begin
        errors++;
        $display("FAIL d2_word %0d got %h at +%0d want %h at +%0d", i, rx2_data[i], rx2_cyc[i] - rx2_cyc[0], exp2[i], offs[i]);
      end
    end
    if (rx2_data.size() > 0 && rd2_cyc.size() > 0) begin
      checks++;
      if (rx2_cyc[0] != rd2_cyc[0] + 2) begin
        errors++; $display("FAIL d2_latency got %0d want 2", rx2_cyc[0] - rd2_cyc[0]);
      end
    end
    exp2.delete();
  endtask

  task automatic test_random();
    clear_logs3();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) push3({$urandom(), $urandom()});
      m_ready3 = ($urandom_range(0, 2) != 0);
      tick();
    end
    m_ready3 = 1'b1;
    for (int k = 0; k < 200 && rx3_data.size() < exp3.size(); k++) tick();
    checks++;
    if (rx3_data.size() != exp3.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", rx3_data.size(), exp3.size());
    end
    for (int i = 0; i < rx3_data.size() && i < exp3.size(); i++) begin
      checks++;
      if (rx3_data[i] !== exp3[i]) begin
        errors++; $display("FAIL rand_word %0d got %h want %h", i, rx3_data[i], exp3[i]);
      end
    end
    checks++;
    if (occ3_max > 3 || stab3_err != 0) begin
      errors++; $display("FAIL rand_hold got occ_max=%0d stab_err=%0d want <=3,0", occ3_max, stab3_err);
    end
    exp3.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_midstream();
    test_depth2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
